reg_access_arbiter: RTL and testbench
=====================================

# reg_access_arbiter

- Shares one software access port of a register slice between REQ_CNT requesters (e.g. APB slave, debug port, on-chip CPU).
- Round-robin arbitration; per-transaction sequencing with a single-cycle read/write strobe, so read side-effect fields (read-clear, read-set) and write-side-effect fields (write-1-to-clear/set/toggle) are triggered exactly once per granted access.
- Sits between the bus-facing slave adaptors and the register slice's per-field software controls; returns read data, error and completion to the winning requester.

## Interface
Parameters:
- REQ_CNT, 2, number of requesters (2..8)
- ADDR_WIDTH, 8, register address width
- DATA_WIDTH, 32, data width
- TIMEOUT, 15, cycles to wait for reg_ack before error; 0 disables timeout

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_vld  input  REQ_CNT  per-requester request; held until matching req_ack
- req_rd  input  REQ_CNT  1 = read, 0 = write
- req_addr  input  REQ_CNT*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  input  REQ_CNT*DATA_WIDTH  packed write data
- req_ack  output  REQ_CNT  one-hot, 1-cycle completion pulse
- req_rdata  output  DATA_WIDTH  read data, valid with req_ack
- req_err  output  1  error flag, valid with req_ack
- reg_wr  output  1  write strobe to register slice
- reg_rd  output  1  read strobe to register slice
- reg_addr  output  ADDR_WIDTH  access address
- reg_wdata  output  DATA_WIDTH  write data
- reg_ack  input  1  slice completion
- reg_rdata  input  DATA_WIDTH  slice read data, valid with reg_ack
- reg_err  input  1  slice error (unmapped address / illegal access), valid with reg_ack

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any req_vld, pick winner by round-robin. Search starts at (last_grant+1) mod REQ_CNT; after reset last_grant = REQ_CNT-1, so requester 0 has top priority. Register grant index, req_rd, req_addr, req_wdata of winner; go to ACCESS.
- ACCESS first cycle: reg_rd = latched rd, or reg_wr = !rd, high for exactly this one cycle. reg_addr/reg_wdata driven from latch for the whole ACCESS stay, else 0.
- ACCESS: on reg_ack, capture reg_rdata (forced to 0 for writes) and reg_err; go to RESP.
- Timeout counter: reset on entry to ACCESS, increments each ACCESS cycle without reg_ack. When it reaches TIMEOUT (TIMEOUT>0), capture rdata=0, err=1; go to RESP. A reg_ack on the same cycle wins over the timeout.
- RESP: req_ack[grant]=1 for one cycle with req_rdata/req_err; update last_grant=grant; go to IDLE.
- reg_ack outside ACCESS is ignored. No strobe is ever reissued for the same transaction.
- Requester dropping req_vld before its ack: protocol violation. Transaction still completes; its req_ack is still pulsed.
- Requests arriving during ACCESS/RESP wait; non-granted requests are never lost (level-held).

## Timing
- Reset (async assert, sync deassert by upstream synchronizer): state IDLE, last_grant=REQ_CNT-1, counter 0, and all outputs 0 (req_ack, req_rdata, req_err, reg_wr, reg_rd, reg_addr, reg_wdata).
- Reset mid-transaction aborts it; no req_ack is issued.
- req_vld seen in IDLE at cycle N:
  - strobe at N+1;
  - reg_ack at N+1 earliest (combinational slice) gives req_ack at N+2;
  - reg_ack at N+k gives req_ack at N+k+1.
- Timeout with no ack: strobe at N+1, req_ack with err at N+1+TIMEOUT+1.
- Back-to-back throughput: one transaction per 3 cycles minimum. The earliest next strobe is 2 cycles after the previous req_ack.
- req_rdata/req_err are registered and hold their value only in the RESP cycle; 0 otherwise.

## Test plan
- Single read, REQ_CNT=2: req_vld=01, rd, addr=0x10. Slice acks the strobe cycle with rdata=0xA5A5_0001. Required: reg_rd one cycle, reg_addr=0x10; req_ack=01 two cycles after request with req_rdata=0xA5A5_0001, err=0.
- Contention: req_vld=11 held continuously, both writes, reg_ack immediate. Required: grants in order 0,1,0,1; each transaction produces exactly one reg_wr pulse with the matching wdata; acks spaced 3 cycles apart.
- Read-clear safety: slice delays reg_ack 4 cycles after the strobe. Required: reg_rd high exactly one cycle; reg_addr stable all 5 ACCESS cycles; req_ack 1 cycle after reg_ack.
- Timeout, TIMEOUT=15: slice never acks. Required: req_ack with req_err=1, req_rdata=0, 17 cycles after request. A later reg_ack is ignored. With TIMEOUT=0 the arbiter waits indefinitely.
- Error passthrough: reg_ack with reg_err=1 on a write to 0xFF. Required: req_err=1 with req_ack; rdata=0.
- Reset mid-ACCESS: assert rst_n low during the wait. Required: all outputs 0 immediately; no req_ack. After release with req_vld=11, requester 0 is granted first.

Source files
------------

// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter
//   Shares the software access port of a register slice between REQ_CNT
//   requesters. It grants round-robin and runs one transaction at a time
//   through IDLE -> ACCESS -> RESP. A single-cycle rd/wr strobe is issued per
//   granted access, so side-effect fields fire exactly once.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_vld/rd/addr/wdata      per-requester request (packed, level-held)
//   req_ack                    one-hot completion pulse (RESP cycle)
//   req_rdata, req_err         response, valid with req_ack, 0 otherwise
//   reg_wr, reg_rd             one-cycle strobes to the register slice
//   reg_addr, reg_wdata        access address/data, held for the whole ACCESS
//   reg_ack, reg_rdata, reg_err slice completion and response
module reg_access_arbiter #(
  parameter int REQ_CNT    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [REQ_CNT-1:0]               req_vld,
  input  logic [REQ_CNT-1:0]               req_rd,
  input  logic [REQ_CNT*ADDR_WIDTH-1:0]    req_addr,
  input  logic [REQ_CNT*DATA_WIDTH-1:0]    req_wdata,
  output logic [REQ_CNT-1:0]               req_ack,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic                             req_err,
  output logic                             reg_wr,
  output logic                             reg_rd,
  output logic [ADDR_WIDTH-1:0]            reg_addr,
  output logic [DATA_WIDTH-1:0]            reg_wdata,
  input  logic                             reg_ack,
  input  logic [DATA_WIDTH-1:0]            reg_rdata,
  input  logic                             reg_err
);

  localparam int GW = (REQ_CNT < 2) ? 1 : $clog2(REQ_CNT);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);
  localparam logic [GW-1:0] LAST_RST = GW'(REQ_CNT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic                    rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [REQ_CNT-1:0]      req_ack_q, req_ack_d;
  logic [DATA_WIDTH-1:0]   req_rdata_q, req_rdata_d;
  logic                    req_err_q, req_err_d;
  logic                    reg_wr_q, reg_wr_d;
  logic                    reg_rd_q, reg_rd_d;
  logic [ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0]   reg_wdata_q, reg_wdata_d;

  // Unpack the per-requester address/data buses.
  logic [ADDR_WIDTH-1:0] addr_arr  [REQ_CNT];
  logic [DATA_WIDTH-1:0] wdata_arr [REQ_CNT];

  for (genvar gi = 0; gi < REQ_CNT; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: scan from last_grant+1 upward. The loop runs from the
  // farthest candidate to the nearest so the nearest requester is kept.
  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] cand_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = REQ_CNT; k >= 1; k--) begin
      cand_idx = GW'((int'(last_grant_q) + k) % REQ_CNT);
      if (req_vld[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    // Pulsed/response outputs default low so they live exactly one cycle.
    reg_wr_d     = 1'b0;
    reg_rd_d     = 1'b0;
    req_ack_d    = '0;
    req_rdata_d  = '0;
    req_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = ACCESS;
          grant_d     = win_idx;
          rd_d        = req_rd[win_idx];
          reg_addr_d  = addr_arr[win_idx];
          reg_wdata_d = wdata_arr[win_idx];
          reg_rd_d    = req_rd[win_idx];
          reg_wr_d    = !req_rd[win_idx];
          cnt_d       = '0;
        end
      end
      ACCESS: begin
        // reg_ack is checked first so a same-cycle ack beats the timeout.
        if (reg_ack) begin
          state_d            = RESP;
          req_ack_d[grant_q] = 1'b1;
          req_rdata_d        = rd_q ? reg_rdata : '0;
          req_err_d          = reg_err;
          reg_addr_d         = '0;
          reg_wdata_d        = '0;
        end else if ((TIMEOUT > 0) && (cnt_q == TO_LIMIT)) begin
          state_d            = RESP;
          req_ack_d[grant_q] = 1'b1;
          req_err_d          = 1'b1;
          reg_addr_d         = '0;
          reg_wdata_d        = '0;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d      = IDLE;
        last_grant_d = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RST;
      grant_q      <= '0;
      rd_q         <= 1'b0;
      cnt_q        <= '0;
      req_ack_q    <= '0;
      req_rdata_q  <= '0;
      req_err_q    <= 1'b0;
      reg_wr_q     <= 1'b0;
      reg_rd_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      req_ack_q    <= req_ack_d;
      req_rdata_q  <= req_rdata_d;
      req_err_q    <= req_err_d;
      reg_wr_q     <= reg_wr_d;
      reg_rd_q     <= reg_rd_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign req_rdata = req_rdata_q;
  assign req_err   = req_err_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench for reg_access_arbiter: stimulus pushes expected strobes
// and responses into queues, a monitor pops and compares them when the DUT
// presents a strobe or a req_ack. A second instance with TIMEOUT=0 checks the
// wait-forever behaviour.
module tb_reg_access_arbiter;
  localparam int RC = 2;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [RC-1:0]    req_vld, req_rd, req_vld_nt;
  logic [RC*AW-1:0] req_addr;
  logic [RC*DW-1:0] req_wdata;
  logic [RC-1:0]    req_ack, req_ack_nt;
  logic [DW-1:0]    req_rdata, req_rdata_nt, reg_wdata, reg_wdata_nt, reg_rdata;
  logic             req_err, req_err_nt, reg_wr, reg_wr_nt, reg_rd, reg_rd_nt;
  logic [AW-1:0]    reg_addr, reg_addr_nt;
  logic             reg_ack, reg_err, reg_ack_nt, reg_err_nt;

  typedef struct { logic [RC-1:0] ack; logic [DW-1:0] rdata; logic err; int cyc; } resp_t;
  typedef struct { logic rd; logic [AW-1:0] addr; logic [DW-1:0] wdata; int cyc; } strb_t;
  resp_t resp_q[$];
  strb_t strb_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int remaining [RC];
  int ack_delay;            // slice ack latency after strobe, <0 = never
  logic [DW-1:0] slice_rdata;
  logic slice_err;
  logic stray_ack;

  assign reg_rdata = slice_rdata;
  assign reg_err   = slice_err;

  reg_access_arbiter #(.REQ_CNT(RC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rd(req_rd), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ack(req_ack), .req_rdata(req_rdata), .req_err(req_err),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err));

  reg_access_arbiter #(.REQ_CNT(RC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld_nt), .req_rd(req_rd), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ack(req_ack_nt), .req_rdata(req_rdata_nt), .req_err(req_err_nt),
    .reg_wr(reg_wr_nt), .reg_rd(reg_rd_nt), .reg_addr(reg_addr_nt), .reg_wdata(reg_wdata_nt),
    .reg_ack(reg_ack_nt), .reg_rdata(reg_rdata), .reg_err(reg_err_nt));

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  // Register slice model plus requester ack handling (drop req_vld when done).
  initial begin
    int pend;
    logic [AW-1:0] held_addr;
    pend = 0;
    held_addr = '0;
    reg_ack = 1'b0;
    forever begin
      @(negedge clk);
      reg_ack = stray_ack;
      if (!rst_n) begin
        pend = 0;
      end else if (reg_rd || reg_wr) begin
        held_addr = reg_addr;
        if (ack_delay == 0) reg_ack = 1'b1;
        else if (ack_delay > 0) pend = ack_delay;
      end else if (pend > 0) begin
        chk("addr_hold", 64'(reg_addr), 64'(held_addr));
        pend--;
        if (pend == 0) reg_ack = 1'b1;
      end
      for (int i = 0; i < RC; i++) begin
        if (req_ack[i]) begin
          if (remaining[i] > 0) remaining[i]--;
          if (remaining[i] == 0) req_vld[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every strobe and every req_ack against the queues.
  initial begin
    resp_t r;
    strb_t s;
    forever begin
      @(negedge clk);
      if (req_ack != '0) begin
        total++;
        if (resp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack ack=%b cyc=%0d required no ack", req_ack, cyc);
        end else begin
          r = resp_q.pop_front();
          if (req_ack !== r.ack || req_rdata !== r.rdata || req_err !== r.err || cyc != r.cyc) begin
            bad++;
            $display("FAIL resp ack=%b/%b rdata=%h/%h err=%b/%b cyc=%0d/%0d (got/required)",
                     req_ack, r.ack, req_rdata, r.rdata, req_err, r.err, cyc, r.cyc);
          end
        end
      end else begin
        total++;
        if (req_rdata !== '0 || req_err !== 1'b0) begin
          bad++;
          $display("FAIL resp_idle rdata=%h err=%b required 0/0 cyc=%0d", req_rdata, req_err, cyc);
        end
      end
      if (reg_rd || reg_wr) begin
        total++;
        if (strb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe rd=%b wr=%b addr=%h cyc=%0d required none", reg_rd, reg_wr, reg_addr, cyc);
        end else begin
          s = strb_q.pop_front();
          if (reg_rd !== s.rd || reg_wr !== !s.rd || reg_addr !== s.addr || reg_wdata !== s.wdata || cyc != s.cyc) begin
            bad++;
            $display("FAIL strobe rd=%b/%b wr=%b addr=%h/%h wdata=%h/%h cyc=%0d/%0d (got/required)",
                     reg_rd, s.rd, reg_wr, reg_addr, s.addr, reg_wdata, s.wdata, cyc, s.cyc);
          end else begin
            $display("strobe ok rd=%b addr=%h wdata=%h cyc=%0d", reg_rd, reg_addr, reg_wdata, cyc);
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req_rd[i] = rd;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic push_s(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] wd, input int c);
    strb_t s;
    s.rd = rd; s.addr = a; s.wdata = wd; s.cyc = c;
    strb_q.push_back(s);
  endtask

  task automatic push_r(input logic [RC-1:0] ack, input logic [DW-1:0] rd, input logic err, input int c);
    resp_t r;
    r.ack = ack; r.rdata = rd; r.err = err; r.cyc = c;
    resp_q.push_back(r);
  endtask

  task automatic drain();
    int waited = 0;
    while ((resp_q.size() != 0 || strb_q.size() != 0 || remaining[0] != 0 || remaining[1] != 0) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (waited >= 300) begin
      bad++;
      $display("FAIL drain_timeout resp_left=%0d strb_left=%0d required 0", resp_q.size(), strb_q.size());
      resp_q.delete();
      strb_q.delete();
      remaining[0] = 0;
      remaining[1] = 0;
      req_vld = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_ack"}, 64'(req_ack), 64'd0);
    chk({tag, "_req_rdata"}, 64'(req_rdata), 64'd0);
    chk({tag, "_req_err"}, 64'(req_err), 64'd0);
    chk({tag, "_strobes"}, 64'({reg_wr, reg_rd}), 64'd0);
    chk({tag, "_reg_addr"}, 64'(reg_addr), 64'd0);
    chk({tag, "_reg_wdata"}, 64'(reg_wdata), 64'd0);
  endtask

  initial begin
    int n;
    int nt_acks;
    int nt_strobes;
    req_vld = '0; req_vld_nt = '0; req_rd = '0; req_addr = '0; req_wdata = '0;
    reg_ack_nt = 1'b0; reg_err_nt = 1'b0; stray_ack = 1'b0;
    ack_delay = 0; slice_rdata = '0; slice_err = 1'b0;
    remaining[0] = 0; remaining[1] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Contention: both write, immediate ack; grants 0,1,0,1, acks 3 apart.
    slice_rdata = 32'hDEAD_BEEF;
    ack_delay = 0;
    set_req(0, 1'b0, 8'h20, 32'h1111_0000);
    set_req(1, 1'b0, 8'h21, 32'h2222_0001);
    n = cyc;
    push_s(1'b0, 8'h20, 32'h1111_0000, n + 1);
    push_s(1'b0, 8'h21, 32'h2222_0001, n + 4);
    push_s(1'b0, 8'h20, 32'h1111_0000, n + 7);
    push_s(1'b0, 8'h21, 32'h2222_0001, n + 10);
    push_r(2'b01, 32'h0, 1'b0, n + 2);
    push_r(2'b10, 32'h0, 1'b0, n + 5);
    push_r(2'b01, 32'h0, 1'b0, n + 8);
    push_r(2'b10, 32'h0, 1'b0, n + 11);
    remaining[0] = 2; remaining[1] = 2;
    req_vld = 2'b11;
    drain();

    // Single read, combinational slice ack.
    slice_rdata = 32'hA5A5_0001;
    set_req(0, 1'b1, 8'h10, 32'h0);
    n = cyc;
    push_s(1'b1, 8'h10, 32'h0, n + 1);
    push_r(2'b01, 32'hA5A5_0001, 1'b0, n + 2);
    remaining[0] = 1;
    req_vld[0] = 1'b1;
    drain();

    // Read with ack 4 cycles after the strobe.
    slice_rdata = 32'h0000_C0DE;
    ack_delay = 4;
    set_req(1, 1'b1, 8'h30, 32'h0);
    n = cyc;
    push_s(1'b1, 8'h30, 32'h0, n + 1);
    push_r(2'b10, 32'h0000_C0DE, 1'b0, n + 6);
    remaining[1] = 1;
    req_vld[1] = 1'b1;
    drain();

    // Timeout on dut; dut_nt (TIMEOUT=0) must keep waiting.
    ack_delay = -1;
    slice_rdata = 32'h5555_AAAA;
    set_req(0, 1'b1, 8'h40, 32'h0);
    n = cyc;
    push_s(1'b1, 8'h40, 32'h0, n + 1);
    push_r(2'b01, 32'h0, 1'b1, n + 17);
    remaining[0] = 1;
    req_vld[0] = 1'b1;
    req_vld_nt[0] = 1'b1;
    nt_acks = 0;
    nt_strobes = 0;
    repeat (40) begin
      @(negedge clk);
      if (req_ack_nt != '0) nt_acks++;
      if (reg_rd_nt || reg_wr_nt) begin
        nt_strobes++;
        chk("nt_strobe_addr", 64'(reg_addr_nt), 64'h40);
        chk("nt_strobe_wdata", 64'(reg_wdata_nt), 64'h0);
      end
    end
    chk("nt_no_ack_while_waiting", 64'(nt_acks), 64'd0);
    chk("nt_single_strobe", 64'(nt_strobes), 64'd1);
    reg_ack_nt = 1'b1;
    @(negedge clk);
    reg_ack_nt = 1'b0;
    req_vld_nt = '0;
    chk("nt_late_ack", 64'(req_ack_nt), 64'b01);
    chk("nt_late_rdata", 64'(req_rdata_nt), 64'h5555_AAAA);
    chk("nt_late_err", 64'(req_err_nt), 64'd0);
    drain();
    // Stray reg_ack after the timeout must be ignored (monitor flags any ack).
    @(posedge clk);
    #1 stray_ack = 1'b1;
    @(posedge clk);
    #1 stray_ack = 1'b0;
    repeat (4) @(negedge clk);

    // Error passthrough on write to 0xFF.
    ack_delay = 0;
    slice_err = 1'b1;
    slice_rdata = 32'hDEAD_BEEF;
    set_req(0, 1'b0, 8'hFF, 32'h0BAD_F00D);
    n = cyc;
    push_s(1'b0, 8'hFF, 32'h0BAD_F00D, n + 1);
    push_r(2'b01, 32'h0, 1'b1, n + 2);
    remaining[0] = 1;
    req_vld[0] = 1'b1;
    drain();
    slice_err = 1'b0;

    // Reset mid-ACCESS: requester 1 aborted, then 0 must win first.
    ack_delay = -1;
    set_req(1, 1'b1, 8'h50, 32'h0);
    n = cyc;
    push_s(1'b1, 8'h50, 32'h0, n + 1);
    remaining[1] = 1;
    req_vld[1] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    ack_delay = 0;
    slice_rdata = 32'h1234_5678;
    set_req(0, 1'b1, 8'h60, 32'h0);
    rst_n = 1'b1;
    n = cyc;
    push_s(1'b1, 8'h60, 32'h0, n + 1);
    push_s(1'b1, 8'h50, 32'h0, n + 4);
    push_r(2'b01, 32'h1234_5678, 1'b0, n + 2);
    push_r(2'b10, 32'h1234_5678, 1'b0, n + 5);
    remaining[0] = 1;
    req_vld[0] = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
